// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state codes, opcode classes,
// mux-select codes and the control word driven toward the datapath.
package ctrl_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXECR  = 4'd6;
  localparam logic [3:0] ST_EXECI  = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;

  typedef enum logic [3:0] {
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    MEMADR = ST_MEMADR,
    MEMRD  = ST_MEMRD,
    MEMWB  = ST_MEMWB,
    MEMWR  = ST_MEMWR,
    EXECR  = ST_EXECR,
    EXECI  = ST_EXECI,
    ALUWB  = ST_ALUWB,
    BRANCH = ST_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic       ADR_PC   = 1'b0;
  localparam logic       ADR_ALU  = 1'b1;
  localparam logic       SRCA_REG = 1'b0;
  localparam logic       SRCA_PC  = 1'b1;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } ctrl_word_t;

  // States whose exit back to FETCH retires an instruction.
  function automatic logic is_retire(input state_t s);
    return (s == MEMWB) || (s == MEMWR) || (s == ALUWB) || (s == BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational control-word table: current state plus cond_ex/mem_ready gating
// produce the datapath enables and mux selects.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: ctrl.adr_src = ADR_ALU;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = cond_ex;
      end
      MEMWR: begin
        ctrl.adr_src   = ADR_ALU;
        ctrl.mem_write = cond_ex & mem_ready;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = 1'b1;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = cond_ex;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.pc_write   = cond_ex;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor main control FSM with retired-instruction counter.
// Define MULTICYCLE_CTRL_STALL_EN to add mem_ready wait states on FETCH/MEMRD/MEMWR.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MULTICYCLE_CTRL_STALL_EN
  input  logic             mem_ready,
`endif
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic             cond_ex,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             alu_op,
  output logic             undef,
  output logic [CNT_W-1:0] instr_cnt
);

`ifdef MULTICYCLE_CTRL_STALL_EN
  logic mem_rdy;
  assign mem_rdy = mem_ready;
`else
  logic mem_rdy;
  assign mem_rdy = 1'b1;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             undef_reg;
  logic             retire;
  ctrl_word_t       ctrl;

  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = funct[5] ? EXECI : EXECR;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = mem_rdy ? MEMWB : MEMRD;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = mem_rdy ? FETCH : MEMWR;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  assign retire = is_retire(state_reg) && (state_next == FETCH);

  // undef is registered: it pulses during the FETCH cycle following an illegal DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
      undef_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      undef_reg <= (state_reg == DECODE) && (op == OP_ILL);
      if (retire) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  ctrl_decoder u_decoder (
    .state     (state_reg),
    .cond_ex   (cond_ex),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl)
  );

  // Enables are masked combinationally so a mid-instruction reset never leaks a write.
  assign pc_write   = ctrl.pc_write  & reset;
  assign ir_write   = ctrl.ir_write  & reset;
  assign reg_write  = ctrl.reg_write & reset;
  assign mem_write  = ctrl.mem_write & reset;
  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_op     = ctrl.alu_op;
  assign undef      = undef_reg;
  assign instr_cnt  = cnt_reg;

endmodule
